// File: rtl/dec_ham.sv
// Hamming (21,16) receive-side decoder: syndrome, single-error correction,
// two-stage valid/ready pipeline and saturating link-quality error counters.
module dec_ham #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [20:0]      dat_i,
    input  logic             vld_i,
    output logic             rdy_o,
    output logic [15:0]      dat_o,
    output logic             vld_o,
    input  logic             rdy_i,
    output logic [4:0]       syn_o,
    output logic             err_cor_o,
    output logic             err_unc_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] cnt_cor_o,
    output logic [CNT_W-1:0] cnt_unc_o
);

    logic             s1Vld_q;
    logic [20:0]      s1Cw_q;
    logic [4:0]       s1Syn_q;
    logic             s2Vld_q;
    logic [15:0]      s2Dat_q;
    logic [4:0]       s2Syn_q;
    logic             s2Cor_q;
    logic             s2Unc_q;
    logic [CNT_W-1:0] cntCor_q;
    logic [CNT_W-1:0] cntCor_d;
    logic [CNT_W-1:0] cntUnc_q;
    logic [CNT_W-1:0] cntUnc_d;

    logic             adv1;
    logic             adv2;
    logic             outHs;
    logic [4:0]       synIn;
    logic             corFlag;
    logic             uncFlag;
    logic [20:0]      cwFix;
    logic [15:0]      datFix;

    // Each syndrome bit covers every position whose index has that bit set.
    function automatic logic [4:0] calcSyndrome(input logic [20:0] cw);
        logic [4:0] s;
        logic [4:0] pos;
        s = '0;
        for (int p = 1; p <= 21; p++) begin
            pos = 5'(p);
            for (int k = 0; k < 5; k++) begin
                if (pos[k]) s[k] = s[k] ^ cw[p-1];
            end
        end
        return s;
    endfunction

    assign adv2  = !s2Vld_q || rdy_i;
    assign adv1  = !s1Vld_q || adv2;
    assign rdy_o = adv1;
    assign outHs = s2Vld_q && rdy_i;
    assign synIn = calcSyndrome(dat_i);

    always_comb begin
        corFlag = (s1Syn_q != 5'd0) && (s1Syn_q <= 5'd21);
        uncFlag = (s1Syn_q > 5'd21);
        cwFix   = s1Cw_q;
        for (int i = 0; i < 21; i++) begin
            if (corFlag && (s1Syn_q == 5'(i + 1))) cwFix[i] = ~s1Cw_q[i];
        end
        datFix = {cwFix[20:16], cwFix[14:8], cwFix[6:4], cwFix[2]};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1Vld_q <= 1'b0;
            s1Cw_q  <= '0;
            s1Syn_q <= '0;
        end else if (adv1) begin
            s1Vld_q <= vld_i;
            if (vld_i) begin
                s1Cw_q  <= dat_i;
                s1Syn_q <= synIn;
            end
        end
    end

    // Output stage only reloads when a real word arrives, so data holds under stall.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s2Vld_q <= 1'b0;
            s2Dat_q <= '0;
            s2Syn_q <= '0;
            s2Cor_q <= 1'b0;
            s2Unc_q <= 1'b0;
        end else if (adv2) begin
            s2Vld_q <= s1Vld_q;
            if (s1Vld_q) begin
                s2Dat_q <= datFix;
                s2Syn_q <= s1Syn_q;
                s2Cor_q <= corFlag;
                s2Unc_q <= uncFlag;
            end
        end
    end

    always_comb begin
        cntCor_d = cntCor_q;
        cntUnc_d = cntUnc_q;
        if (clr_cnt_i) begin
            cntCor_d = '0;
            cntUnc_d = '0;
        end else if (outHs) begin
            if (s2Cor_q && (cntCor_q != '1)) cntCor_d = cntCor_q + CNT_W'(1);
            if (s2Unc_q && (cntUnc_q != '1)) cntUnc_d = cntUnc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cntCor_q <= '0;
            cntUnc_q <= '0;
        end else begin
            cntCor_q <= cntCor_d;
            cntUnc_q <= cntUnc_d;
        end
    end

    assign dat_o     = s2Dat_q;
    assign vld_o     = s2Vld_q;
    assign syn_o     = s2Syn_q;
    assign err_cor_o = s2Cor_q;
    assign err_unc_o = s2Unc_q;
    assign cnt_cor_o = cntCor_q;
    assign cnt_unc_o = cntUnc_q;

endmodule

// File: tb/tb_dec_ham.sv
// Directed bench for dec_ham: vector table, backpressure stream, counter
// saturation/clear with a narrow-counter instance, and asynchronous reset.
module tb_dec_ham;

    typedef struct {
        logic [20:0] cw;
        logic [15:0] dat;
        logic [4:0]  syn;
        logic        cor;
        logic        unc;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [20:0] dat_i;
    logic        vld_i;
    logic        rdy_i;
    logic        clr_cnt_i;
    logic        rdy_o;
    logic [15:0] dat_o;
    logic        vld_o;
    logic [4:0]  syn_o;
    logic        err_cor_o;
    logic        err_unc_o;
    logic [15:0] cnt_cor_o;
    logic [15:0] cnt_unc_o;
    logic        rdyNarrow;
    logic [15:0] datNarrow;
    logic        vldNarrow;
    logic [4:0]  synNarrow;
    logic        corNarrow;
    logic        uncNarrow;
    logic [1:0]  cntCorNarrow;
    logic [1:0]  cntUncNarrow;

    int checkCount = 0;
    int passCount  = 0;
    int expCor     = 0;
    int expUnc     = 0;

    always #5 clk_i = ~clk_i;

    dec_ham dut (
        .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .vld_i(vld_i), .rdy_o(rdy_o),
        .dat_o(dat_o), .vld_o(vld_o), .rdy_i(rdy_i), .syn_o(syn_o),
        .err_cor_o(err_cor_o), .err_unc_o(err_unc_o), .clr_cnt_i(clr_cnt_i),
        .cnt_cor_o(cnt_cor_o), .cnt_unc_o(cnt_unc_o)
    );

    dec_ham #(.CNT_W(2)) dutNarrow (
        .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .vld_i(vld_i), .rdy_o(rdyNarrow),
        .dat_o(datNarrow), .vld_o(vldNarrow), .rdy_i(rdy_i), .syn_o(synNarrow),
        .err_cor_o(corNarrow), .err_unc_o(uncNarrow), .clr_cnt_i(clr_cnt_i),
        .cnt_cor_o(cntCorNarrow), .cnt_unc_o(cntUncNarrow)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Reference encoder: places data bits, then sets each check bit for even parity.
    function automatic logic [20:0] encode(input logic [15:0] d);
        logic [20:0] cw;
        logic [4:0]  pos;
        logic        par;
        cw = '0;
        cw[2]     = d[0];
        cw[6:4]   = d[3:1];
        cw[14:8]  = d[10:4];
        cw[20:16] = d[15:11];
        for (int k = 0; k < 5; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 21; p++) begin
                pos = 5'(p);
                if (pos[k] && (p != (1 << k))) par = par ^ cw[p-1];
            end
            cw[(1 << k) - 1] = par;
        end
        return cw;
    endfunction

    task automatic checkCounters(input string tag);
        int narrowCor;
        int narrowUnc;
        narrowCor = (expCor > 3) ? 3 : expCor;
        narrowUnc = (expUnc > 3) ? 3 : expUnc;
        checkOutput({tag, "_cntCor"}, 32'(cnt_cor_o), 32'(expCor));
        checkOutput({tag, "_cntUnc"}, 32'(cnt_unc_o), 32'(expUnc));
        checkOutput({tag, "_cntCorNarrow"}, 32'(cntCorNarrow), 32'(narrowCor));
        checkOutput({tag, "_cntUncNarrow"}, 32'(cntUncNarrow), 32'(narrowUnc));
    endtask

    // Sends one word with rdy_i high and checks two-cycle latency and decoded fields.
    task automatic applyStimulus(input string tag, input vec_t v);
        dat_i = v.cw;
        vld_i = 1'b1;
        rdy_i = 1'b1;
        #2;
        checkOutput({tag, "_rdyIn"}, 32'(rdy_o), 32'd1);
        tick;
        vld_i = 1'b0;
        dat_i = '0;
        #2;
        checkOutput({tag, "_vldEarly"}, 32'(vld_o), 32'd0);
        tick;
        #2;
        checkOutput({tag, "_vld"}, 32'(vld_o), 32'd1);
        checkOutput({tag, "_dat"}, 32'(dat_o), 32'(v.dat));
        checkOutput({tag, "_syn"}, 32'(syn_o), 32'(v.syn));
        checkOutput({tag, "_cor"}, 32'(err_cor_o), 32'(v.cor));
        checkOutput({tag, "_unc"}, 32'(err_unc_o), 32'(v.unc));
        tick;
        if (v.cor) expCor++;
        if (v.unc) expUnc++;
        #2;
        checkCounters(tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        vec_t        vecs[7];
        vec_t        v;
        logic [15:0] payloads[8];
        int          sent;
        int          got;
        logic        prevStall;
        logic [15:0] prevDat;
        logic        accepted;
        logic        delivered;

        vecs[0] = '{cw: 21'h000000, dat: 16'h0000, syn: 5'd0,  cor: 1'b0, unc: 1'b0};
        vecs[1] = '{cw: 21'h1FFFFE, dat: 16'hFFFF, syn: 5'd0,  cor: 1'b0, unc: 1'b0};
        vecs[2] = '{cw: 21'h1FFFFF, dat: 16'hFFFF, syn: 5'd1,  cor: 1'b1, unc: 1'b0};
        vecs[3] = '{cw: 21'h100000, dat: 16'h0000, syn: 5'd21, cor: 1'b1, unc: 1'b0};
        vecs[4] = '{cw: 21'h000004, dat: 16'h0000, syn: 5'd3,  cor: 1'b1, unc: 1'b0};
        vecs[5] = '{cw: 21'h100002, dat: 16'h8000, syn: 5'd23, cor: 1'b0, unc: 1'b1};
        vecs[6] = '{cw: 21'h000003, dat: 16'h0001, syn: 5'd3,  cor: 1'b1, unc: 1'b0};
        payloads = '{16'h1234, 16'hABCD, 16'h0001, 16'h8000, 16'hFFFF, 16'h5A5A, 16'h0F0F, 16'hC3C3};

        rst_i     = 1'b0;
        dat_i     = '0;
        vld_i     = 1'b0;
        rdy_i     = 1'b0;
        clr_cnt_i = 1'b0;
        #3;
        checkOutput("rst_vld", 32'(vld_o), 32'd0);
        checkOutput("rst_dat", 32'(dat_o), 32'd0);
        checkCounters("rst");
        tick;
        tick;
        rst_i = 1'b1;
        #2;
        checkOutput("rst_rdyAfter", 32'(rdy_o), 32'd1);

        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        $display("[TB] counter clear, saturation and clear-vs-increment");
        clr_cnt_i = 1'b1;
        tick;
        clr_cnt_i = 1'b0;
        expCor = 0;
        expUnc = 0;
        #2;
        checkCounters("clr");
        rdy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dat_i = 21'h000004;
            vld_i = 1'b1;
            tick;
        end
        vld_i = 1'b0;
        dat_i = '0;
        tick;
        tick;
        tick;
        expCor = 5;
        #2;
        checkCounters("sat");
        dat_i = 21'h000004;
        vld_i = 1'b1;
        tick;
        vld_i = 1'b0;
        tick;
        #2;
        checkOutput("clrHs_vld", 32'(vld_o), 32'd1);
        clr_cnt_i = 1'b1;
        tick;
        clr_cnt_i = 1'b0;
        expCor = 0;
        #2;
        checkCounters("clrHs");

        $display("[TB] backpressure stream");
        sent = 0;
        got = 0;
        prevStall = 1'b0;
        prevDat = '0;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            vld_i = (sent < 8);
            dat_i = (sent < 8) ? encode(payloads[sent]) : 21'h0;
            rdy_i = 1'($urandom_range(0, 1));
            #2;
            if (prevStall) checkOutput("bp_stable", 32'(dat_o), 32'(prevDat));
            checkOutput("bp_rdy", 32'(rdy_o), 32'(!(((sent - got) == 2) && !rdy_i)));
            prevStall = vld_o && !rdy_i;
            prevDat   = dat_o;
            accepted  = vld_i && rdy_o;
            delivered = vld_o && rdy_i;
            if (delivered) begin
                checkOutput($sformatf("bp_dat%0d", got), 32'(dat_o), 32'(payloads[got]));
                got++;
            end
            if (accepted) sent++;
            tick;
        end
        checkOutput("bp_drain", 32'(got), 32'd8);
        vld_i = 1'b0;
        dat_i = '0;
        rdy_i = 1'b1;
        tick;
        tick;

        v = '{cw: 21'h000004, dat: 16'h0000, syn: 5'd3, cor: 1'b1, unc: 1'b0};
        applyStimulus("preRst", v);

        $display("[TB] asynchronous reset with two words in flight");
        rdy_i = 1'b0;
        dat_i = 21'h100002;
        vld_i = 1'b1;
        tick;
        dat_i = 21'h000004;
        tick;
        vld_i = 1'b0;
        dat_i = '0;
        #2;
        checkOutput("inflight_unc", 32'(err_unc_o), 32'd1);
        checkOutput("inflight_rdy", 32'(rdy_o), 32'd0);
        #1;
        rst_i = 1'b0;
        #1;
        expCor = 0;
        expUnc = 0;
        checkOutput("arst_vld", 32'(vld_o), 32'd0);
        checkOutput("arst_dat", 32'(dat_o), 32'd0);
        checkOutput("arst_syn", 32'(syn_o), 32'd0);
        checkOutput("arst_cor", 32'(err_cor_o), 32'd0);
        checkOutput("arst_unc", 32'(err_unc_o), 32'd0);
        checkCounters("arst");
        #1;
        rst_i = 1'b1;
        #1;
        checkOutput("arst_rdyAfter", 32'(rdy_o), 32'd1);
        tick;
        v = '{cw: encode(16'h1234), dat: 16'h1234, syn: 5'd0, cor: 1'b0, unc: 1'b0};
        applyStimulus("postRst", v);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dec_ham.md
Name: dec_ham

Overview:
- Receive side of the Hamming (21,16) link. Consumes the 21-bit codewords the encoder produces and computes the 5-bit syndrome.
- Corrects any single-bit error, flags syndromes that point outside the codeword as uncorrectable, and returns the 16-bit payload.
- Two-stage pipeline with valid/ready on both sides. Saturating error counters for link-quality monitoring.

Parameters:
CNT_W, 16, width of each saturating error counter.

Ports:
clk_i  input  1  clock, all logic on rising edge.
rst_i  input  1  reset, asynchronous, active-low.
dat_i  input  21  codeword; bit p-1 holds Hamming position p (1..21).
vld_i  input  1  dat_i valid.
rdy_o  output  1  decoder can accept; combinational.
dat_o  output  16  decoded payload.
vld_o  output  1  dat_o valid.
rdy_i  input  1  downstream accepts.
syn_o  output  5  syndrome aligned with dat_o.
err_cor_o  output  1  single error corrected in current word.
err_unc_o  output  1  uncorrectable syndrome in current word.
clr_cnt_i  input  1  synchronous clear of both counters.
cnt_cor_o  output  CNT_W  count of corrected words.
cnt_unc_o  output  CNT_W  count of uncorrectable words.

Behaviour:
- Codeword layout, bit index = position-1:
  - Check bits c0..c4 at indices 0, 1, 3, 7, 15.
  - Data bits: d0 at 2, d3:d1 at 6:4, d10:d4 at 14:8, d15:d11 at 20:16.
- Syndrome: s[k] = XOR of all codeword bits whose position has bit k set, check bit included. Range 0..31.
- Classification:
  - s=0: clean; data passes unchanged.
  - s in 1..21: invert codeword bit s-1, then extract data; err_cor=1. A flipped check bit still sets err_cor, and data is unchanged.
  - s in 22..31: err_unc=1; data extracted from the uncorrected codeword.
- Limitation: the code has no overall parity bit. A double error that aliases into 1..21 is miscorrected and reported as err_cor. This is accepted.
- Stage 1 registers the codeword and syndrome. Stage 2 registers the corrected data, syn_o and the flags.
- Handshakes:
  - Transfer occurs on vld&&rdy at each interface.
  - Stage-2 advance condition: adv2 = !vld_o || rdy_i.
  - Stage-1 advance condition: adv1 = !s1_vld || adv2.
  - rdy_o = adv1. It must not depend on vld_i.
- Latency and throughput:
  - Latency is 2 cycles from input handshake to vld_o when not stalled.
  - Throughput is 1 word/cycle with rdy_i held high.
- Stall: while vld_o && !rdy_i, dat_o, syn_o and the flags hold stable. Stage 1 holds if occupied. No word is dropped or duplicated.
- Bubbles: an empty stage advances regardless of rdy_i.
- Counters:
  - Each counter increments only on an output handshake (vld_o&&rdy_i) carrying the matching flag.
  - Counters saturate at 2^CNT_W-1 with no wrap.
  - clr_cnt_i clears both counters next edge. Clear takes priority over a simultaneous increment.
- Reset (rst_i low), asynchronous:
  - Pipeline valids, dat_o, syn_o, err_cor_o, err_unc_o, cnt_cor_o and cnt_unc_o all go to 0.
  - rdy_o reads 1 once reset is released.
  - Reset mid-stream discards all in-flight words.

Test Plan:
- Clean words: dat_i=0x000000, then 0x1FFFFE → dat_o=0x0000, then 0xFFFF. syn=0, no flags, counters 0; vld_o two cycles after each accept.
- Single-error correction, three checks:
  - 0x1FFFFF → dat_o=0xFFFF, syn=1, err_cor=1.
  - 0x100000 → dat_o=0x0000, syn=21, err_cor=1.
  - 0x000004 → dat_o=0x0000, syn=3, err_cor=1.
  - cnt_cor_o=3 after all three are accepted.
- Uncorrectable: 0x100002 → syn=23, err_unc=1, dat_o=0x8000 (uncorrected), cnt_unc_o=1. Aliased double error 0x000003 → syn=3, dat_o=0x0001, err_cor=1.
- Backpressure: stream 8 words with vld_i high, rdy_i toggling randomly.
  - Outputs match the input order exactly.
  - dat_o stays stable whenever vld_o&&!rdy_i.
  - rdy_o=0 only when both stages are full and rdy_i=0.
- Counters:
  - With CNT_W=2, 5 corrected words → cnt_cor_o stops at 3.
  - clr_cnt_i asserted in the same cycle as a corrected handshake → counter reads 0.
- Reset: assert rst_i low asynchronously with 2 words in flight → all outputs 0 immediately, with no clock edge needed; after release, the next word decodes with 2-cycle latency.
